lomo_receiver: RTL and testbench

LOMO_RECEIVER -- requirements
Module: lomo_receiver

---
 rtl/lomo_receiver_pkg.sv | 20 ++
 rtl/lomo_receiver_if.sv | 30 +++
 rtl/lomo_receiver_sync_edge.sv | 26 ++
 rtl/lomo_receiver.sv | 142 ++++++++++++++
 tb/tb_lomo_receiver.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lomo_receiver_pkg.sv
// Shared types and defaults for the LOMO serial receiver and its frame generator.
// Word width, frame length and link timeout live here so both sides agree.
package lomo_receiver_pkg;

  localparam int DEF_WORD_BITS   = 12;
  localparam int DEF_FRAME_WORDS = 16;
  localparam int DEF_TIMEOUT_CYC = 400;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } rxStateT;

  // Index width that stays legal for a single-word frame.
  function automatic int idxBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lomo_receiver_if.sv
// Pin-side serial link (mk/sclk/dat) plus the assembled-word and status outputs.
// master = frame generator / consumer side, slave = receiver.
interface lomo_receiver_if
  import lomo_receiver_pkg::*;
#(
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
);
  localparam int IDX_BITS = idxBits(FRAME_WORDS);

  logic                 mk;
  logic                 sclk;
  logic                 dat;
  logic [WORD_BITS-1:0] word;
  logic                 word_valid;
  logic [IDX_BITS-1:0]  word_idx;
  logic                 frame_done;
  logic                 frame_err;
  logic                 link_lost;

  modport master (
    output mk, sclk, dat,
    input  word, word_valid, word_idx, frame_done, frame_err, link_lost
  );

  modport slave (
    input  mk, sclk, dat,
    output word, word_valid, word_idx, frame_done, frame_err, link_lost
  );
endinterface

// File: rtl/lomo_receiver_sync_edge.sv
// Two-flop synchronizer with a rising-edge detect on the synchronized value.
// Edge is combinational off the sync and previous flops (3 cycles pin-to-use).
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic syncOut,
  output logic riseEdge
);
  logic meta;
  logic syncPrev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b0;
      syncOut  <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      meta     <= pin;
      syncOut  <= meta;
      syncPrev <= syncOut;
    end
  end

  assign riseEdge = syncOut & ~syncPrev;
endmodule

// File: rtl/lomo_receiver.sv
// LOMO serial frame receiver: assembles MSB-first words between mk edges.
//   state | meaning
//   ARM   | after reset: wait for mk low so a frame in flight is dropped
//   IDLE  | wait for mk high (frame start)
//   RECV  | shift bits on sclk rising edges until mk falls
module lomo_receiver
  import lomo_receiver_pkg::*;
#(
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic            clk,
  input logic            reset,
  lomo_receiver_if.slave bus
);
  localparam int IDX_BITS      = idxBits(FRAME_WORDS);
  localparam int BIT_CNT_BITS  = $clog2(WORD_BITS + 1);
  localparam int WORD_CNT_BITS = $clog2(FRAME_WORDS + 1);
  localparam int TMO_BITS      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BIT_CNT_BITS-1:0]  LAST_BIT  = BIT_CNT_BITS'(WORD_BITS - 1);
  localparam logic [WORD_CNT_BITS-1:0] ALL_WORDS = WORD_CNT_BITS'(FRAME_WORDS);
  localparam logic [TMO_BITS-1:0]      TMO_MAX   = TMO_BITS'(TIMEOUT_CYC);

  logic mkS, sclkS, datS;
  logic sclkEdge, mkRise, datRise;
  logic unusedEdges;

  sync_edge uSyncMk   (.clk(clk), .reset(reset), .pin(bus.mk),   .syncOut(mkS),   .riseEdge(mkRise));
  sync_edge uSyncSclk (.clk(clk), .reset(reset), .pin(bus.sclk), .syncOut(sclkS), .riseEdge(sclkEdge));
  sync_edge uSyncDat  (.clk(clk), .reset(reset), .pin(bus.dat),  .syncOut(datS),  .riseEdge(datRise));

  assign unusedEdges = mkRise ^ datRise ^ sclkS;

  rxStateT state, stateNext;
  logic [1:0] warmCnt;
  logic warm;
  logic startFrame, takeBit, closeFrame;

  // The mk synchronizer reads 0 straight out of reset; wait for it to fill
  // before trusting a low, otherwise a frame in flight would be re-armed.
  always_ff @(posedge clk) begin
    if (reset) warmCnt <= 2'd0;
    else if (warmCnt != 2'd2) warmCnt <= warmCnt + 2'd1;
  end
  assign warm = (warmCnt == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) state <= ARM;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      ARM:     if (warm && !mkS) stateNext = IDLE;
      IDLE:    if (mkS)          stateNext = RECV;
      RECV:    if (!mkS)         stateNext = IDLE;
      default:                   stateNext = ARM;
    endcase
  end

  always_comb begin
    startFrame = (state == IDLE) && mkS;
    takeBit    = sclkEdge && mkS && ((state == IDLE) || (state == RECV));
    closeFrame = (state == RECV) && !mkS;
  end

  logic [BIT_CNT_BITS-1:0]  bitCnt, bitBase;
  logic [WORD_CNT_BITS-1:0] wordCnt, wordBase;
  logic                     overrun, overBase;
  logic [WORD_BITS-1:0]     shiftReg, shiftNext;
  logic [WORD_BITS:0]       shiftCat;
  logic [WORD_BITS-1:0]     wordReg;
  logic [IDX_BITS-1:0]      wordIdx;
  logic                     wordValid, frameDone, frameErr;

  // A frame start clears the counters in the same cycle its first bit lands.
  always_comb begin
    bitBase   = startFrame ? '0 : bitCnt;
    wordBase  = startFrame ? '0 : wordCnt;
    overBase  = startFrame ? 1'b0 : overrun;
    shiftCat  = {shiftReg, datS};
    shiftNext = shiftCat[WORD_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitCnt    <= '0;
      wordCnt   <= '0;
      overrun   <= 1'b0;
      shiftReg  <= '0;
      wordReg   <= '0;
      wordIdx   <= '0;
      wordValid <= 1'b0;
      frameDone <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      wordValid <= 1'b0;
      frameDone <= 1'b0;
      frameErr  <= 1'b0;
      bitCnt    <= bitBase;
      wordCnt   <= wordBase;
      overrun   <= overBase;
      if (takeBit) begin
        if (wordBase == ALL_WORDS) begin
          overrun <= 1'b1;
        end else begin
          shiftReg <= shiftNext;
          if (bitBase == LAST_BIT) begin
            wordReg   <= shiftNext;
            wordIdx   <= wordBase[IDX_BITS-1:0];
            wordValid <= 1'b1;
            wordCnt   <= wordBase + 1'b1;
            bitCnt    <= '0;
          end else begin
            bitCnt <= bitBase + 1'b1;
          end
        end
      end
      if (closeFrame) begin
        if ((bitCnt == '0) && (wordCnt == ALL_WORDS) && !overrun) frameDone <= 1'b1;
        else                                                       frameErr  <= 1'b1;
      end
    end
  end

  logic [TMO_BITS-1:0] tmoCnt;

  always_ff @(posedge clk) begin
    if (reset)                  tmoCnt <= '0;
    else if (sclkEdge)          tmoCnt <= '0;
    else if (tmoCnt != TMO_MAX) tmoCnt <= tmoCnt + 1'b1;
  end

  assign bus.word       = wordReg;
  assign bus.word_valid = wordValid;
  assign bus.word_idx   = wordIdx;
  assign bus.frame_done = frameDone;
  assign bus.frame_err  = frameErr;
  assign bus.link_lost  = (tmoCnt == TMO_MAX);
endmodule

// File: tb/tb_lomo_receiver.sv
// Directed bench for lomo_receiver: 12-bit words, 4-word frames, sclk = clk/40.
// A monitor logs strobes; each test task compares the log against hand values.
module tb_lomo_receiver;
  import lomo_receiver_pkg::*;

  localparam int WB  = 12;
  localparam int FW  = 4;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  lomo_receiver_if #(.WORD_BITS(WB), .FRAME_WORDS(FW)) bus ();

  lomo_receiver #(.WORD_BITS(WB), .FRAME_WORDS(FW), .TIMEOUT_CYC(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [WB-1:0] wordQ[$];
  logic [1:0]    idxQ[$];
  int doneCnt = 0;
  int errCnt = 0;

  always @(posedge clk) begin
    #1;
    if (bus.word_valid) begin
      wordQ.push_back(bus.word);
      idxQ.push_back(bus.word_idx);
    end
    if (bus.frame_done) doneCnt++;
    if (bus.frame_err)  errCnt++;
  end

  localparam logic [63:0] FULL_BITS  = {16'h0, 12'hABC, 12'h123, 12'hFFF, 12'h000};
  localparam logic [63:0] SHORT_BITS = {34'h0, 12'h5A5, 12'h3C3, 6'b101101};
  localparam logic [63:0] OVER_BITS  = {14'h0, 12'h801, 12'h7FE, 12'h0F0, 12'hA5A, 2'b11};

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearMon();
    wordQ.delete();
    idxQ.delete();
    doneCnt = 0;
    errCnt  = 0;
  endtask

  task automatic sendBit(input logic b);
    bus.dat = b;
    cycles(10);
    bus.sclk = 1'b1;
    cycles(20);
    bus.sclk = 1'b0;
    cycles(10);
  endtask

  // First sclk edge coincides with the mk rise (must be sampled); the mk fall
  // coincides with one more sclk edge (must be ignored).
  task automatic runFrame(input logic [63:0] bits, input int n);
    bus.dat  = bits[n-1];
    bus.mk   = 1'b1;
    bus.sclk = 1'b1;
    cycles(20);
    bus.sclk = 1'b0;
    cycles(20);
    for (int i = n - 2; i >= 0; i--) sendBit(bits[i]);
    cycles(10);
    bus.mk   = 1'b0;
    bus.sclk = 1'b1;
    cycles(20);
    bus.sclk = 1'b0;
    cycles(30);
  endtask

  task automatic test_reset();
    logic [WB+5:0] obs;
    reset = 1'b1;
    bus.mk = 1'b0;
    bus.sclk = 1'b0;
    bus.dat = 1'b0;
    cycles(4);
    obs = {bus.word, bus.word_valid, bus.word_idx, bus.frame_done, bus.frame_err, bus.link_lost};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    reset = 1'b0;
    cycles(1);
    obs = {bus.word, bus.word_valid, bus.word_idx, bus.frame_done, bus.frame_err, bus.link_lost};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL post_reset_outputs: got %h expected 0", obs);
    end
    cycles(20);
  endtask

  task automatic test_full_frame();
    logic [WB-1:0] expW[4];
    expW = '{12'hABC, 12'h123, 12'hFFF, 12'h000};
    clearMon();
    runFrame(FULL_BITS, 48);
    checks++;
    if (wordQ.size() !== 4) begin
      failures++;
      $display("FAIL full_word_count: got %0d expected 4", wordQ.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wordQ.size()) begin
        checks++;
        if (wordQ[i] !== expW[i] || idxQ[i] !== 2'(i)) begin
          failures++;
          $display("FAIL full_word%0d: got %h idx %0d expected %h idx %0d", i, wordQ[i], idxQ[i], expW[i], i);
        end
      end
    end
    checks++;
    if (doneCnt !== 1 || errCnt !== 0) begin
      failures++;
      $display("FAIL full_closure: got done=%0d err=%0d expected done=1 err=0", doneCnt, errCnt);
    end
  endtask

  task automatic test_short_frame();
    clearMon();
    runFrame(SHORT_BITS, 30);
    checks++;
    if (wordQ.size() !== 2) begin
      failures++;
      $display("FAIL short_word_count: got %0d expected 2", wordQ.size());
    end
    if (wordQ.size() >= 2) begin
      checks++;
      if (wordQ[0] !== 12'h5A5 || wordQ[1] !== 12'h3C3 || idxQ[0] !== 2'd0 || idxQ[1] !== 2'd1) begin
        failures++;
        $display("FAIL short_words: got %h/%h idx %0d/%0d expected 5a5/3c3 idx 0/1", wordQ[0], wordQ[1], idxQ[0], idxQ[1]);
      end
    end
    checks++;
    if (doneCnt !== 0 || errCnt !== 1) begin
      failures++;
      $display("FAIL short_closure: got done=%0d err=%0d expected done=0 err=1", doneCnt, errCnt);
    end
  endtask

  task automatic test_overrun();
    logic [WB-1:0] expW[4];
    expW = '{12'h801, 12'h7FE, 12'h0F0, 12'hA5A};
    clearMon();
    runFrame(OVER_BITS, 50);
    checks++;
    if (wordQ.size() !== 4) begin
      failures++;
      $display("FAIL over_word_count: got %0d expected 4", wordQ.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wordQ.size()) begin
        checks++;
        if (wordQ[i] !== expW[i] || idxQ[i] !== 2'(i)) begin
          failures++;
          $display("FAIL over_word%0d: got %h idx %0d expected %h idx %0d", i, wordQ[i], idxQ[i], expW[i], i);
        end
      end
    end
    checks++;
    if (doneCnt !== 0 || errCnt !== 1) begin
      failures++;
      $display("FAIL over_closure: got done=%0d err=%0d expected done=0 err=1", doneCnt, errCnt);
    end
  endtask

  task automatic test_reset_midframe();
    logic [WB-1:0] expW[4];
    expW = '{12'hABC, 12'h123, 12'hFFF, 12'h000};
    bus.mk = 1'b1;
    cycles(10);
    for (int i = 47; i >= 28; i--) sendBit(FULL_BITS[i]);
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    clearMon();
    for (int i = 27; i >= 18; i--) sendBit(FULL_BITS[i]);
    cycles(10);
    bus.mk = 1'b0;
    cycles(40);
    checks++;
    if (wordQ.size() !== 0 || doneCnt !== 0 || errCnt !== 0) begin
      failures++;
      $display("FAIL midreset_quiet: got words=%0d done=%0d err=%0d expected 0/0/0", wordQ.size(), doneCnt, errCnt);
    end
    clearMon();
    runFrame(FULL_BITS, 48);
    checks++;
    if (wordQ.size() !== 4) begin
      failures++;
      $display("FAIL midreset_next_count: got %0d expected 4", wordQ.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wordQ.size()) begin
        checks++;
        if (wordQ[i] !== expW[i] || idxQ[i] !== 2'(i)) begin
          failures++;
          $display("FAIL midreset_word%0d: got %h idx %0d expected %h idx %0d", i, wordQ[i], idxQ[i], expW[i], i);
        end
      end
    end
    checks++;
    if (doneCnt !== 1 || errCnt !== 0) begin
      failures++;
      $display("FAIL midreset_closure: got done=%0d err=%0d expected done=1 err=0", doneCnt, errCnt);
    end
  endtask

  // k counts clk edges after the sclk pin rise; the timer clears at k=3 and
  // reaches TMO again at k = TMO + 3.
  task automatic test_link_lost();
    clearMon();
    cycles(TMO + 10);
    checks++;
    if (bus.link_lost !== 1'b1) begin
      failures++;
      $display("FAIL link_lost_idle: got %b expected 1", bus.link_lost);
    end
    bus.sclk = 1'b1;
    for (int k = 1; k <= TMO + 50; k++) begin
      cycles(1);
      if (k == 20) bus.sclk = 1'b0;
      if (k == 2) begin
        checks++;
        if (bus.link_lost !== 1'b1) begin
          failures++;
          $display("FAIL link_lost_hold: got %b expected 1", bus.link_lost);
        end
      end
      if (k == 3) begin
        checks++;
        if (bus.link_lost !== 1'b0) begin
          failures++;
          $display("FAIL link_lost_clear: got %b expected 0", bus.link_lost);
        end
      end
      if (k == TMO + 2) begin
        checks++;
        if (bus.link_lost !== 1'b0) begin
          failures++;
          $display("FAIL link_lost_early: got %b expected 0", bus.link_lost);
        end
      end
      if (k == TMO + 3) begin
        checks++;
        if (bus.link_lost !== 1'b1) begin
          failures++;
          $display("FAIL link_lost_set: got %b expected 1", bus.link_lost);
        end
      end
    end
    checks++;
    if (bus.link_lost !== 1'b1 || wordQ.size() !== 0 || doneCnt !== 0 || errCnt !== 0) begin
      failures++;
      $display("FAIL link_lost_saturate: got lost=%b words=%0d done=%0d err=%0d expected 1/0/0/0",
               bus.link_lost, wordQ.size(), doneCnt, errCnt);
    end
  endtask

  // Starts with link_lost high: frames must still be received, back to back.
  task automatic test_back_to_back();
    logic [WB-1:0] expW[8];
    expW = '{12'hABC, 12'h123, 12'hFFF, 12'h000, 12'h801, 12'h7FE, 12'h0F0, 12'hA5A};
    clearMon();
    runFrame(FULL_BITS, 48);
    runFrame(OVER_BITS >> 2, 48);
    checks++;
    if (wordQ.size() !== 8) begin
      failures++;
      $display("FAIL b2b_word_count: got %0d expected 8", wordQ.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < wordQ.size()) begin
        checks++;
        if (wordQ[i] !== expW[i] || idxQ[i] !== 2'(i % 4)) begin
          failures++;
          $display("FAIL b2b_word%0d: got %h idx %0d expected %h idx %0d", i, wordQ[i], idxQ[i], expW[i], i % 4);
        end
      end
    end
    checks++;
    if (doneCnt !== 2 || errCnt !== 0) begin
      failures++;
      $display("FAIL b2b_closure: got done=%0d err=%0d expected done=2 err=0", doneCnt, errCnt);
    end
  endtask

  initial begin
    bus.mk   = 1'b0;
    bus.sclk = 1'b0;
    bus.dat  = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overrun();
    test_reset_midframe();
    test_link_lost();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
